// File: rtl/design_info_streamer_pkg.sv
// Shared encodings and widths for the design-info APB-to-byte-stream block.
package design_info_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int         BW_NUM_WORDS  = 5;
  localparam int         BW_BYTE_INDEX = 2;
  localparam logic [7:0] NUL_BYTE      = 8'h00;

endpackage

// File: rtl/design_info_word_serializer.sv
// Holds one fetched 32-bit word and hands it out lowest byte first over a
// valid/ready byte interface, flagging a NUL byte instead of emitting it.
module design_info_word_serializer
  import design_info_streamer_pkg::*;
#(
  parameter bit STOP_AT_NUL = 1'b1
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        word_consumed,
  output logic        nul_hit
);

  logic [31:0]              word_q, word_d;
  logic [BW_BYTE_INDEX-1:0] idx_q, idx_d;
  logic                     active_q, active_d;
  logic [7:0]               cur_byte;
  logic                     is_nul;
  logic                     xfer;

  always_comb begin
    cur_byte = word_q[7:0];
    case (idx_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
  end

  // Handshake: a byte moves only on a cycle with byte_valid && byte_ready;
  // until then byte_data/byte_valid hold, since idx_q and word_q only move on
  // that cycle. A NUL byte (when enabled) never raises byte_valid.
  assign is_nul        = STOP_AT_NUL && (cur_byte == NUL_BYTE);
  assign byte_valid    = active_q && !is_nul;
  assign byte_data     = cur_byte;
  assign nul_hit       = active_q && is_nul;
  assign xfer          = byte_valid && byte_ready;
  assign word_consumed = xfer && (&idx_q);

  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load) begin
      word_d   = load_word;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (nul_hit) begin
      active_d = 1'b0;
    end else if (xfer) begin
      if (&idx_q) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      word_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/design_info_streamer.sv
// Reads a run of 32-bit words from an APB design-info region, one transfer at
// a time, and streams their characters out byte by byte until count or NUL.
module design_info_streamer
  import design_info_streamer_pkg::*;
#(
  parameter int                 BW_ADDR     = 32,
  parameter logic [BW_ADDR-1:0] BASE_ADDR   = '0,
  parameter int                 STOP_AT_NUL = 1
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [BW_ADDR-1:0]      req_offset,
  input  logic [BW_NUM_WORDS-1:0] req_num_words,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [BW_ADDR-1:0]      paddr,
  output logic [31:0]             pwdata,
  input  logic [31:0]             prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    done,
  output logic                    done_error,
  output logic                    busy,
  output state_e                  dbg_state
);

  state_e                  state_q, state_d;
  logic [BW_ADDR-1:0]      offset_q, offset_d;
  logic [BW_NUM_WORDS-1:0] count_q, count_d;
  logic [BW_NUM_WORDS-1:0] index_q, index_d;
  logic                    err_q, err_d;
  logic [BW_ADDR-1:0]      paddr_q, paddr_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    done_q, done_d;
  logic                    done_error_q, done_error_d;
  logic                    req_ready_q, req_ready_d;
  logic                    busy_q, busy_d;
  logic                    load;
  logic                    word_consumed;
  logic                    nul_hit;

  // Word address wraps silently at 2^BW_ADDR; the low two offset bits are dropped.
  function automatic logic [BW_ADDR-1:0] word_addr(input logic [BW_ADDR-1:0]      off,
                                                   input logic [BW_NUM_WORDS-1:0] idx);
    return BASE_ADDR + {off[BW_ADDR-1:2], 2'b00} + BW_ADDR'({idx, 2'b00});
  endfunction

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    count_d  = count_q;
    index_d  = index_q;
    err_d    = err_q;
    paddr_d  = paddr_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          offset_d = {req_offset[BW_ADDR-1:2], 2'b00};
          count_d  = req_num_words;
          index_d  = '0;
          if (req_num_words == '0) begin
            state_d = ST_DONE;
          end else begin
            paddr_d = word_addr(req_offset, '0);
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (nul_hit) begin
          state_d = ST_DONE;
        end else if (word_consumed) begin
          if (index_q == count_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            paddr_d = word_addr(offset_q, index_q + 1'b1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered: derived from the state being entered.
    psel_d       = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d    = (state_d == ST_ACCESS);
    done_d       = (state_d == ST_DONE);
    done_error_d = (state_d == ST_DONE) && err_d;
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      count_q      <= '0;
      index_q      <= '0;
      err_q        <= 1'b0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      done_q       <= 1'b0;
      done_error_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      index_q      <= index_d;
      err_q        <= err_d;
      paddr_q      <= paddr_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      done_q       <= done_d;
      done_error_q <= done_error_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  design_info_word_serializer #(
    .STOP_AT_NUL(STOP_AT_NUL != 0)
  ) u_serializer (
    .clk          (clk),
    .rstnn        (rstnn),
    .load         (load),
    .load_word    (prdata),
    .byte_ready   (byte_ready),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .word_consumed(word_consumed),
    .nul_hit      (nul_hit)
  );

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = 1'b0;
  assign pwdata     = '0;
  assign paddr      = paddr_q;
  assign done       = done_q;
  assign done_error = done_error_q;
  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_design_info_streamer.sv
// Bench for design_info_streamer: an APB slave memory, a byte sink with stalls,
// and byte/address scoreboards filled from a reference walk of the memory.
module tb_design_info_streamer;
  import design_info_streamer_pkg::*;

  logic        clk;
  logic        rstnn;
  logic        req_valid;
  logic [31:0] req_offset;
  logic [4:0]  req_num_words;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        byte_ready;
  logic        sel;

  logic        a_req_ready, a_psel, a_penable, a_pwrite, a_byte_valid, a_done, a_done_error, a_busy;
  logic [31:0] a_paddr, a_pwdata;
  logic [7:0]  a_byte_data;
  state_e      a_state;
  logic        n_req_ready, n_psel, n_penable, n_pwrite, n_byte_valid, n_done, n_done_error, n_busy;
  logic [31:0] n_paddr, n_pwdata;
  logic [7:0]  n_byte_data;
  state_e      n_state;

  logic        m_req_ready, m_psel, m_penable, m_byte_valid, m_done, m_done_error, m_busy;
  logic [31:0] m_paddr;
  logic [7:0]  m_byte_data;

  logic [31:0] mem [0:31];
  logic        err_en;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];

  bit got_done, got_err;
  int first_valid, done_cyc, apb_cnt, last_xfer, stall_seen;

  design_info_streamer dut_a (
    .clk(clk), .rstnn(rstnn), .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_offset(req_offset), .req_num_words(req_num_words),
    .psel(a_psel), .penable(a_penable), .pwrite(a_pwrite), .paddr(a_paddr), .pwdata(a_pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .byte_valid(a_byte_valid), .byte_ready(byte_ready), .byte_data(a_byte_data),
    .done(a_done), .done_error(a_done_error), .busy(a_busy), .dbg_state(a_state)
  );

  design_info_streamer #(.STOP_AT_NUL(0)) dut_n (
    .clk(clk), .rstnn(rstnn), .req_valid(req_valid && sel), .req_ready(n_req_ready),
    .req_offset(req_offset), .req_num_words(req_num_words),
    .psel(n_psel), .penable(n_penable), .pwrite(n_pwrite), .paddr(n_paddr), .pwdata(n_pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .byte_valid(n_byte_valid), .byte_ready(byte_ready), .byte_data(n_byte_data),
    .done(n_done), .done_error(n_done_error), .busy(n_busy), .dbg_state(n_state)
  );

  assign m_req_ready  = sel ? n_req_ready  : a_req_ready;
  assign m_psel       = sel ? n_psel       : a_psel;
  assign m_penable    = sel ? n_penable    : a_penable;
  assign m_byte_valid = sel ? n_byte_valid : a_byte_valid;
  assign m_done       = sel ? n_done       : a_done;
  assign m_done_error = sel ? n_done_error : a_done_error;
  assign m_busy       = sel ? n_busy       : a_busy;
  assign m_paddr      = sel ? n_paddr      : a_paddr;
  assign m_byte_data  = sel ? n_byte_data  : a_byte_data;

  assign prdata  = mem[m_paddr[6:2]];
  assign pslverr = err_en && (m_paddr == err_addr);

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Reference walk of the memory: addresses and bytes the block should produce.
  task automatic push_expected(input logic [31:0] off, input int n, input bit stop_nul,
                               output bit exp_err);
    exp_err = 1'b0;
    for (int w = 0; w < n; w++) begin
      logic [31:0] a;
      a = (off & 32'hFFFF_FFFC) + 32'(4 * w);
      exp_addr_q.push_back(a);
      if (err_en && a == err_addr) begin
        exp_err = 1'b1;
        return;
      end
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by = 8'(mem[a[6:2]] >> (8 * b));
        if (stop_nul && by == 8'h00) return;
        exp_q.push_back(by);
      end
    end
  endtask

  // Driver: present one request for one clock, return at the following negedge.
  task automatic issue_req(input logic [31:0] off, input logic [4:0] n);
    req_offset    = off;
    req_num_words = n;
    req_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Sink/slave driver plus scoreboard pops, one iteration per cycle until done.
  task automatic collect(input int budget, input int stall_k, input int stall_n,
                         input int max_wait, input bit poke);
    int nbytes, stall_left, wait_left;
    logic [7:0]  eb;
    logic [31:0] ea;
    got_done = 1'b0; got_err = 1'b0; first_valid = -1; done_cyc = -1;
    apb_cnt = 0; last_xfer = -1; stall_seen = 0;
    nbytes = 0; stall_left = stall_n; wait_left = 0;
    for (int cyc = 1; cyc <= budget && !got_done; cyc++) begin
      if (m_psel && !m_penable) begin
        apb_cnt++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL apb_addr: unexpected access paddr=%h, none expected", m_paddr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (m_paddr !== ea) begin
            errors++;
            $display("FAIL apb_addr: paddr=%h expected %h", m_paddr, ea);
          end
        end
        wait_left = $urandom_range(0, max_wait);
      end
      pready = !(m_psel && m_penable && wait_left > 0);
      if (m_psel && m_penable && wait_left > 0) wait_left--;

      if (m_byte_valid && nbytes == stall_k && stall_left > 0) begin
        byte_ready = 1'b0;
        stall_left--;
        stall_seen++;
        checks++;
        if (exp_q.size() == 0 || m_byte_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_hold: byte_data=%h expected %h", m_byte_data,
                   exp_q.size() ? exp_q[0] : 8'hxx);
        end
      end else begin
        byte_ready = 1'b1;
      end

      if (m_byte_valid) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (m_psel !== 1'b0) begin
          errors++;
          $display("FAIL no_prefetch: psel=%b expected 0 while bytes pending", m_psel);
        end
      end
      if (m_byte_valid && byte_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_data: unexpected byte %h, none expected", m_byte_data);
        end else begin
          eb = exp_q.pop_front();
          if (m_byte_data !== eb) begin
            errors++;
            $display("FAIL byte_data: got %h expected %h", m_byte_data, eb);
          end
        end
        nbytes++;
        last_xfer = cyc;
      end

      if (poke) begin
        if (cyc == 2) begin
          req_offset = 32'h40; req_num_words = 5'd1; req_valid = 1'b1;
        end else if (cyc == 3) begin
          req_valid = 1'b0;
        end
      end

      if (m_done) begin
        got_done = 1'b1;
        got_err  = m_done_error;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    byte_ready = 1'b1;
    pready     = 1'b1;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: %b expected 1", m_req_ready); end
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL reset_psel: %b expected 0", m_psel); end
    checks++; if (m_penable !== 1'b0) begin errors++; $display("FAIL reset_penable: %b expected 0", m_penable); end
    checks++; if (m_paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr: %h expected 0", m_paddr); end
    checks++; if (m_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: %b expected 0", m_byte_valid); end
    checks++; if (m_byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: %h expected 00", m_byte_data); end
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done: %b expected 0", m_done); end
    checks++; if (m_done_error !== 1'b0) begin errors++; $display("FAIL reset_done_error: %b expected 0", m_done_error); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b expected 0", m_busy); end
    checks++; if (a_pwrite !== 1'b0 || a_pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwrite: pwrite=%b pwdata=%h expected 0", a_pwrite, a_pwdata); end
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    checks++; if (m_req_ready !== 1'b1 || m_busy !== 1'b0) begin errors++; $display("FAIL idle_after_release: req_ready=%b busy=%b expected 1/0", m_req_ready, m_busy); end
  endtask

  task automatic check_end(input string name, input bit exp_err);
    checks++; if (got_err !== exp_err) begin errors++; $display("FAIL %s_done_error: %b expected %b", name, got_err, exp_err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_bytes_left: %0d expected 0", name, exp_q.size()); end
    checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL %s_apb_left: %0d expected 0", name, exp_addr_q.size()); end
    @(negedge clk);
    checks++; if (m_done !== 1'b0 || m_req_ready !== 1'b1) begin errors++; $display("FAIL %s_done_pulse: done=%b req_ready=%b expected 0/1", name, m_done, m_req_ready); end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_basic();
    bit e;
    sel = 1'b0;
    mem[0] = 32'h5F58_5652;
    mem[1] = 32'h004E_4E42;
    push_expected(32'h0, 4, 1'b1, e);
    issue_req(32'h0, 5'd4);
    collect(200, -1, 0, 0, 1'b0);
    checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency: first byte_valid cycle %0d expected 3", first_valid); end
    checks++; if (apb_cnt != 2) begin errors++; $display("FAIL basic_apb_count: %0d expected 2", apb_cnt); end
    check_end("basic", e);
  endtask

  task automatic test_no_stop();
    bit e;
    sel = 1'b1;
    push_expected(32'h0, 2, 1'b0, e);
    issue_req(32'h0, 5'd2);
    collect(200, -1, 0, 0, 1'b0);
    checks++; if (done_cyc != last_xfer + 1) begin errors++; $display("FAIL nostop_done_timing: done cycle %0d expected %0d", done_cyc, last_xfer + 1); end
    checks++; if (apb_cnt != 2) begin errors++; $display("FAIL nostop_apb_count: %0d expected 2", apb_cnt); end
    check_end("nostop", e);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    bit e;
    push_expected(32'h0, 2, 1'b1, e);
    issue_req(32'h0, 5'd2);
    collect(200, 2, 5, 0, 1'b0);
    checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles: %0d expected 5", stall_seen); end
    check_end("bp", e);
  endtask

  task automatic test_slverr();
    bit e;
    mem[4] = 32'h4443_4241;
    mem[5] = 32'h4847_4645;
    err_en = 1'b1;
    err_addr = 32'h14;
    push_expected(32'h10, 4, 1'b1, e);
    issue_req(32'h10, 5'd4);
    collect(200, -1, 0, 1, 1'b0);
    checks++; if (apb_cnt != 2) begin errors++; $display("FAIL slverr_apb_count: %0d expected 2", apb_cnt); end
    check_end("slverr", e);
    err_en = 1'b0;
  endtask

  task automatic test_zero_words();
    bit e;
    push_expected(32'h8, 0, 1'b1, e);
    issue_req(32'h8, 5'd0);
    collect(20, -1, 0, 0, 1'b0);
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: %0d expected 1", done_cyc); end
    checks++; if (apb_cnt != 0) begin errors++; $display("FAIL zero_apb_count: %0d expected 0", apb_cnt); end
    check_end("zero", e);
  endtask

  task automatic test_busy_ignore();
    bit e;
    mem[2] = 32'h6463_6261;
    mem[3] = 32'h6867_6665;
    push_expected(32'h8, 2, 1'b1, e);
    issue_req(32'h8, 5'd2);
    collect(200, -1, 0, 0, 1'b1);
    check_end("busy_ignore", e);
    repeat (3) begin
      checks++;
      if (m_psel !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore_queued: psel=%b busy=%b expected 0/0", m_psel, m_busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit e;
    int n, naddr;
    logic [31:0] off;
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 32; w++) begin
        for (int b = 0; b < 4; b++) begin
          mem[w][8*b +: 8] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
      end
      n   = $urandom_range(1, 6);
      off = 32'($urandom_range(0, 20) * 4 + $urandom_range(0, 3));
      push_expected(off, n, 1'b1, e);
      naddr = exp_addr_q.size();
      issue_req(off, 5'(n));
      collect(600, $urandom_range(0, 8), $urandom_range(0, 3), 3, 1'b0);
      checks++; if (apb_cnt != naddr) begin errors++; $display("FAIL random_apb_count: %0d expected %0d", apb_cnt, naddr); end
      check_end("random", e);
    end
  endtask

  task automatic test_reset_access();
    bit e;
    int k;
    mem[0] = 32'h5F58_5652;
    mem[1] = 32'h004E_4E42;
    issue_req(32'h0, 5'd1);
    pready = 1'b0;
    k = 0;
    while (!(m_psel && m_penable) && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++; if (!(m_psel && m_penable)) begin errors++; $display("FAIL rst_reach_access: psel=%b penable=%b expected 1/1", m_psel, m_penable); end
    #1 rstnn = 1'b0;
    #1;
    checks++; if (m_psel !== 1'b0 || m_penable !== 1'b0) begin errors++; $display("FAIL rst_apb_drop: psel=%b penable=%b expected 0/0", m_psel, m_penable); end
    checks++; if (m_req_ready !== 1'b1 || m_busy !== 1'b0) begin errors++; $display("FAIL rst_req_ready: req_ready=%b busy=%b expected 1/0", m_req_ready, m_busy); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: done=%b expected 0", m_done); end
    end
    pready = 1'b1;
    rstnn  = 1'b1;
    @(negedge clk);
    push_expected(32'h0, 2, 1'b1, e);
    issue_req(32'h0, 5'd2);
    collect(200, -1, 0, 0, 1'b0);
    checks++; if (!got_done) begin errors++; $display("FAIL rst_recover_done: got_done=%b expected 1", got_done); end
    check_end("rst_recover", e);
  endtask

  initial begin
    rstnn = 1'b0; req_valid = 1'b0; req_offset = '0; req_num_words = '0;
    pready = 1'b1; byte_ready = 1'b1; sel = 1'b0; err_en = 1'b0; err_addr = '0;
    for (int w = 0; w < 32; w++) mem[w] = 32'h3030_3030 + 32'(w);
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_no_stop();
    test_backpressure();
    test_slverr();
    test_zero_words();
    test_busy_ignore();
    test_random();
    test_reset_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/design_info_streamer.md
DESIGN_INFO_STREAMER -- requirements
Module: design_info_streamer

Interface
REQ-001 Parameter BW_ADDR, default 32, APB address width.
REQ-002 Parameter BASE_ADDR, default 0, byte base address of the design-info APB region.
REQ-003 Parameter STOP_AT_NUL, default 1, nonzero = a 0x00 byte terminates the transfer.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rstnn  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request strobe.
REQ-007 req_ready  output  1  high only in IDLE.
REQ-008 req_offset  input  BW_ADDR  byte offset into region; bits [1:0] ignored, treated as 0.
REQ-009 req_num_words  input  5  words to fetch, 0..31.
REQ-010 psel, penable, pwrite  output  1 each  APB master controls; pwrite is constantly 0.
REQ-011 paddr  output  BW_ADDR  APB address.
REQ-012 pwdata  output  32  constant 0.
REQ-013 prdata  input  32  APB read data.
REQ-014 pready, pslverr  input  1 each  APB completion and error.
REQ-015 byte_valid  output  1  byte stream valid.
REQ-016 byte_ready  input  1  byte stream ready.
REQ-017 byte_data  output  8  character.
REQ-018 done  output  1  one-cycle pulse at end of transfer.
REQ-019 done_error  output  1  valid with done; 1 = terminated by pslverr.
REQ-020 busy  output  1  high whenever not in IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, ACCESS, EMIT, DONE.
REQ-022 IDLE: req_valid&req_ready latches offset and count and clears index. Next state is DONE if count==0, else SETUP.
REQ-023 SETUP, one cycle: psel=1, penable=0, paddr=BASE_ADDR+{offset[BW_ADDR-1:2],2'b00}+4*index (modulo 2^BW_ADDR, wraps silently). Next state is ACCESS.
REQ-024 ACCESS: psel=1, penable=1, paddr held. It waits indefinitely for pready.
REQ-025 ACCESS with pready&pslverr: set error flag, discard prdata, go to DONE.
REQ-026 ACCESS with pready&!pslverr: latch prdata into word buffer, clear byte index, go to EMIT.
REQ-027 EMIT: byte_data = buffer byte [8*b+7:8*b], b=0 first (lowest byte = first character).
REQ-028 EMIT: byte_valid=1 except when STOP_AT_NUL and the current byte is 0x00. In that case the FSM goes to DONE without emitting the byte.
REQ-029 byte_data and byte_valid SHALL stay stable until byte_valid&byte_ready. A byte transfers only on that cycle.
REQ-030 After byte b=3 transfers: if index+1==count, go to DONE; else increment index and go to SETUP.
REQ-031 DONE, one cycle: done=1, done_error=error flag. Then go to IDLE and clear the error flag.
REQ-032 Minimum cost per word is SETUP + ACCESS + 4 EMIT cycles. From request acceptance to first byte_valid is 3 cycles with zero-wait APB.
REQ-033 The block SHALL NOT prefetch. At most one APB transfer is outstanding. psel=0 outside SETUP/ACCESS.
REQ-034 req_valid while busy SHALL be ignored, not queued.

Reset
REQ-035 Asynchronous assertion of rstnn SHALL force IDLE immediately.
REQ-036 All outputs SHALL reset to 0 except req_ready=1: psel, penable, paddr, byte_valid, byte_data, done, done_error, busy.
REQ-037 Reset mid-ACCESS SHALL drop psel/penable in the same cycle. No done is generated for the aborted transfer.
REQ-038 Release of rstnn is synchronised externally. The first state change is permitted on the first clk edge after deassertion.

Structure
REQ-039 A shared header SHALL hold the state encodings (3 bits), BW_NUM_WORDS=5, BW_BYTE_INDEX=2 and the NUL constant 8'h00.
REQ-040 One sub-module, design_info_word_serializer, SHALL hold the word buffer, byte index, NUL detect and valid/ready handshake.
REQ-041 design_info_word_serializer SHALL signal word_consumed and nul_hit to the FSM.

Verification
REQ-042 Slave returns "RVX_" as 0x5F585652, then "BNN\0" as 0x004E4E42; req_offset=0, num_words=4 -> bytes 52,56,58,5F,42,4E,4E, 2 APB reads at paddr 0x0,0x4, done=1, done_error=0.
REQ-043 STOP_AT_NUL=0, same data, num_words=2 -> 8 bytes including 00, done after 8th byte.
REQ-044 byte_ready held low 5 cycles on byte 2 of word 0 -> byte_data=0x58 held stable, no APB activity until all 4 bytes are consumed.
REQ-045 pslverr=1 on word index 1 (paddr BASE+0x14 with offset 0x10), num_words=4 -> only word 0 bytes emitted, done=1, done_error=1, no third APB access.
REQ-046 num_words=0 -> no psel, done pulse 1 cycle after acceptance, done_error=0.
REQ-047 rstnn low during ACCESS with pready=0 -> psel=0 and req_ready=1 immediately. A new request after release completes normally.
